// File: rtl/kamacore_stage_mem_lsu.sv
// Memory stage: runs loads/stores over a valid/ready data bus, extends load
// data, flags misaligned accesses and registers the MEM/WB buffer.
// Forwarding from EX/MEM covers ALU results only.
module kamacore_stage_mem_lsu #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ex_valid,
   output logic                   ex_ready,
   input  logic [XLEN-1:0]        ex_alu_result,
   input  logic [XLEN-1:0]        ex_store_data,
   input  logic                   ex_mem_re,
   input  logic                   ex_mem_we,
   input  logic [1:0]             ex_size,
   input  logic                   ex_unsigned,
   input  logic [REG_W-1:0]       ex_rd,
   input  logic                   ex_rd_we,
   output logic                   dmem_req_valid,
   input  logic                   dmem_req_ready,
   output logic [ADDR_W-1:0]      dmem_addr,
   output logic                   dmem_we,
   output logic [XLEN/8-1:0]      dmem_be,
   output logic [XLEN-1:0]        dmem_wdata,
   input  logic                   dmem_rsp_valid,
   input  logic [XLEN-1:0]        dmem_rdata,
   output logic                   wb_valid,
   output logic [XLEN-1:0]        wb_result,
   output logic [REG_W-1:0]       wb_rd,
   output logic                   wb_rd_we,
   output logic                   wb_misalign,
   output logic                   fwd_we,
   output logic [REG_W-1:0]       fwd_a,
   output logic [XLEN-1:0]        fwd_data
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

   state_t            r_state;
   state_t            w_next;

   logic              w_mem;
   logic              w_mis;
   logic              w_take;
   logic [OFFW-1:0]   w_off;
   logic [NB-1:0]     w_be_base;
   logic [XLEN-1:0]   w_lane;
   logic [XLEN-1:0]   w_load;

   // Captured operation, held stable while the bus access is in flight
   logic [ADDR_W-1:0] r_addr;
   logic [OFFW-1:0]   r_off;
   logic              r_we;
   logic [NB-1:0]     r_be;
   logic [XLEN-1:0]   r_wdata;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [REG_W-1:0]  r_rd;
   logic              r_rd_we;

   logic              r_wb_valid;
   logic [XLEN-1:0]   r_wb_result;
   logic [REG_W-1:0]  r_wb_rd;
   logic              r_wb_rd_we;
   logic              r_wb_misalign;

   // Sign- or zero-extend the low 1/2/4 bytes (or pass the full word)
   function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                input logic [1:0] sz,
                                                input logic uns);
      logic [XLEN-1:0] v;
      case (sz)
         2'd0:    if (uns) v = XLEN'(d[7:0]);  else v = XLEN'($signed(d[7:0]));
         2'd1:    if (uns) v = XLEN'(d[15:0]); else v = XLEN'($signed(d[15:0]));
         2'd2:    if (uns) v = XLEN'(d[31:0]); else v = XLEN'($signed(d[31:0]));
         default: v = d;
      endcase
      return v;
   endfunction

   assign w_mem  = ex_mem_re | ex_mem_we;
   assign w_off  = ex_alu_result[OFFW-1:0];
   assign w_take = (r_state == S_IDLE) & ex_valid & w_mem & ~w_mis;
   assign w_lane = dmem_rdata >> {r_off, 3'b000};
   assign w_load = f_extend(w_lane, r_size, r_uns);

   // Misalignment and lane mask for the incoming operation
   always_comb begin
      case (ex_size)
         2'd0:    w_mis = 1'b0;
         2'd1:    w_mis = ex_alu_result[0];
         2'd2:    w_mis = |ex_alu_result[1:0];
         default: w_mis = |ex_alu_result[2:0];
      endcase
      case (ex_size)
         2'd0:    w_be_base = NB'(1);
         2'd1:    w_be_base = NB'(3);
         2'd2:    w_be_base = NB'(15);
         default: w_be_base = '1;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_next = S_REQ;
         S_REQ:   if (dmem_req_ready) w_next = r_we ? S_IDLE : S_RSP;
         S_RSP:   if (dmem_rsp_valid) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: accept new ops only when idle, request only in REQ
   always_comb begin
      ex_ready       = 1'b0;
      dmem_req_valid = 1'b0;
      case (r_state)
         S_IDLE:  ex_ready       = 1'b1;
         S_REQ:   dmem_req_valid = 1'b1;
         default: ;
      endcase
   end

   // Capture the memory op on acceptance (data path, no reset needed)
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_addr  <= {ex_alu_result[ADDR_W-1:OFFW], {OFFW{1'b0}}};
         r_off   <= w_off;
         r_we    <= ex_mem_we;
         r_be    <= w_be_base << w_off;
         r_wdata <= ex_store_data << {w_off, 3'b000};
         r_size  <= ex_size;
         r_uns   <= ex_unsigned;
         r_rd    <= ex_rd;
         r_rd_we <= ex_rd_we;
      end
   end

   // MEM/WB buffer: one-cycle valid pulse per retired instruction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_valid    <= 1'b0;
         r_wb_result   <= '0;
         r_wb_rd       <= '0;
         r_wb_rd_we    <= 1'b0;
         r_wb_misalign <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (ex_valid && (!w_mem || w_mis)) begin
               // ALU op retires directly; misaligned op reports the faulting address
               r_wb_valid    <= 1'b1;
               r_wb_result   <= ex_alu_result;
               r_wb_rd       <= ex_rd;
               r_wb_rd_we    <= ex_rd_we & ~w_mem;
               r_wb_misalign <= w_mem;
            end
            S_REQ: if (dmem_req_ready && r_we) begin
               r_wb_valid    <= 1'b1;
               r_wb_result   <= '0;
               r_wb_rd       <= r_rd;
               r_wb_rd_we    <= 1'b0;
               r_wb_misalign <= 1'b0;
            end
            S_RSP: if (dmem_rsp_valid) begin
               r_wb_valid    <= 1'b1;
               r_wb_result   <= w_load;
               r_wb_rd       <= r_rd;
               r_wb_rd_we    <= r_rd_we;
               r_wb_misalign <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign dmem_addr   = r_addr;
   assign dmem_we     = r_we;
   assign dmem_be     = r_be;
   assign dmem_wdata  = r_wdata;

   assign wb_valid    = r_wb_valid;
   assign wb_result   = r_wb_result;
   assign wb_rd       = r_wb_rd;
   assign wb_rd_we    = r_wb_rd_we;
   assign wb_misalign = r_wb_misalign;

   // Loads are never forwarded; load-use is handled by the EX hazard stall
   assign fwd_we   = ex_valid & ex_rd_we & ~ex_mem_re;
   assign fwd_a    = ex_rd;
   assign fwd_data = ex_alu_result;

endmodule

// File: tb/tb_kamacore_stage_mem_lsu.sv
// Bench for kamacore_stage_mem_lsu: table of single-cycle ops plus hand
// sequences for bus handshakes; retirements checked through a scoreboard.
module tb_kamacore_stage_mem_lsu;

   localparam int XLEN = 32;
   localparam int ADDR_W = 32;
   localparam int REG_W = 5;

   logic              clk;
   logic              rst;
   logic              ex_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   ex_alu_result;
   logic [XLEN-1:0]   ex_store_data;
   logic              ex_mem_re;
   logic              ex_mem_we;
   logic [1:0]        ex_size;
   logic              ex_unsigned;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_rd_we;
   logic              dmem_req_valid;
   logic              dmem_req_ready;
   logic [ADDR_W-1:0] dmem_addr;
   logic              dmem_we;
   logic [3:0]        dmem_be;
   logic [XLEN-1:0]   dmem_wdata;
   logic              dmem_rsp_valid;
   logic [XLEN-1:0]   dmem_rdata;
   logic              wb_valid;
   logic [XLEN-1:0]   wb_result;
   logic [REG_W-1:0]  wb_rd;
   logic              wb_rd_we;
   logic              wb_misalign;
   logic              fwd_we;
   logic [REG_W-1:0]  fwd_a;
   logic [XLEN-1:0]   fwd_data;

   kamacore_stage_mem_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
      .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we),
      .wb_misalign(wb_misalign), .fwd_we(fwd_we), .fwd_a(fwd_a), .fwd_data(fwd_data)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rd_we;
      logic        mis;
      logic        chk_res;
   } wb_exp_t;

   typedef struct {
      logic [31:0] alu;
      logic        re;
      logic        we;
      logic [1:0]  sz;
      logic [4:0]  rd;
      logic        rd_we;
      logic        exp_fwd;
      logic        exp_mis;
      logic        exp_rdwe;
   } vec_t;

   wb_exp_t sb_q[$];
   vec_t    vt[7];
   int      n_cmp = 0;
   int      n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic re,
                        input logic we, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic rdwe);
      ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd;
      ex_mem_re = re; ex_mem_we = we; ex_size = sz; ex_unsigned = uns;
      ex_rd = rd; ex_rd_we = rdwe;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_rd_we = 1'b0;
   endtask

   task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic rdwe,
                       input logic mis, input logic chk_res);
      wb_exp_t e;
      e.res = res; e.rd = rd; e.rd_we = rdwe; e.mis = mis; e.chk_res = chk_res;
      sb_q.push_back(e);
   endtask

   // Scoreboard: every retirement must match the oldest expected entry
   always @(negedge clk) begin
      if (rst && wb_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected: got wb_valid=1 (rd=%0d) expected no retirement", wb_rd);
         end else begin
            wb_exp_t e;
            e = sb_q.pop_front();
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_rd_we", wb_rd_we, e.rd_we);
            chk("wb_misalign", wb_misalign, e.mis);
            if (e.chk_res) chk("wb_result", wb_result, e.res);
         end
      end
   end

   // Load: request accepted immediately, response after 'waits' idle RSP cycles
   task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_res);
      dmem_req_ready = 1'b1;
      drive(addr, 32'h0, 1'b1, 1'b0, sz, uns, rd, 1'b1);
      @(negedge clk);
      chk("ld_fwd_we_zero", fwd_we, 1'b0);
      push(exp_res, rd, 1'b1, 1'b0, 1'b1);
      tick();
      idle_ex();
      @(negedge clk);
      chk("ld_req_valid", dmem_req_valid, 1'b1);
      chk("ld_req_we", dmem_we, 1'b0);
      chk("ld_addr", dmem_addr, exp_addr);
      chk("ld_be", dmem_be, exp_be);
      tick();
      dmem_req_ready = 1'b0;
      dmem_rdata = 32'hFFFF_FFFF;
      for (int w = 0; w < waits; w++) begin
         @(negedge clk);
         chk("ld_wait_ex_ready", ex_ready, 1'b0);
         chk("ld_wait_no_req", dmem_req_valid, 1'b0);
         chk("ld_wait_no_wb", wb_valid, 1'b0);
         tick();
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata = rdata;
      tick();
      dmem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("ld_retire", wb_valid, 1'b1);
      chk("ld_ex_ready_back", ex_ready, 1'b1);
      tick();
   endtask

   // Store: bus holds req_ready low for 'stall' cycles; ex_* is scrambled meanwhile
   task automatic run_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data,
                            input int stall, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] wd_mask);
      dmem_req_ready = (stall == 0);
      drive(addr, data, 1'b0, 1'b1, sz, 1'b0, 5'd2, 1'b0);
      @(negedge clk);
      chk("st_ex_ready", ex_ready, 1'b1);
      push(32'h0, 5'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drive(32'hFFFF_FFF0, 32'h1111_1111, 1'b0, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1);
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) dmem_req_ready = 1'b1;
         @(negedge clk);
         chk("st_req_valid", dmem_req_valid, 1'b1);
         chk("st_we", dmem_we, 1'b1);
         chk("st_addr", dmem_addr, exp_addr);
         chk("st_be", dmem_be, exp_be);
         chk("st_wdata", dmem_wdata & wd_mask, exp_wd);
         chk("st_ex_ready_low", ex_ready, 1'b0);
         tick();
      end
      dmem_req_ready = 1'b0;
      idle_ex();
      @(negedge clk);
      chk("st_retire", wb_valid, 1'b1);
      chk("st_no_req_after", dmem_req_valid, 1'b0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      idle_ex();
      ex_alu_result = '0; ex_store_data = '0; ex_size = 2'd0; ex_unsigned = 1'b0; ex_rd = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;

      vt[0] = '{32'h0000_1234, 1'b0, 1'b0, 2'd2, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1};
      vt[1] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[2] = '{32'h0000_0055, 1'b0, 1'b0, 2'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
      vt[3] = '{32'h0000_0206, 1'b1, 1'b0, 2'd2, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0};
      vt[4] = '{32'h0000_0101, 1'b1, 1'b0, 2'd1, 5'd4,  1'b1, 1'b0, 1'b1, 1'b0};
      vt[5] = '{32'h0000_0302, 1'b0, 1'b1, 2'd2, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
      vt[6] = '{32'h0000_00FF, 1'b0, 1'b1, 2'd1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_req_valid", dmem_req_valid, 1'b0);
      chk("rst_wb_rd_we", wb_rd_we, 1'b0);
      chk("rst_wb_misalign", wb_misalign, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_release_ex_ready", ex_ready, 1'b1);
      tick();

      // Single-cycle ops: ALU results and misaligned accesses, back to back
      for (int i = 0; i < 7; i++) begin
         drive(vt[i].alu, 32'h0, vt[i].re, vt[i].we, vt[i].sz, 1'b0, vt[i].rd, vt[i].rd_we);
         @(negedge clk);
         chk("tbl_fwd_we", fwd_we, vt[i].exp_fwd);
         chk("tbl_fwd_a", fwd_a, vt[i].rd);
         chk("tbl_fwd_data", fwd_data, vt[i].alu);
         chk("tbl_ex_ready", ex_ready, 1'b1);
         chk("tbl_no_req", dmem_req_valid, 1'b0);
         if (i > 0) chk("tbl_lat1_wb_valid", wb_valid, 1'b1);
         push(vt[i].alu, vt[i].rd, vt[i].exp_rdwe, vt[i].exp_mis, !vt[i].exp_mis);
         tick();
      end
      idle_ex();
      @(negedge clk);
      chk("tbl_last_wb_valid", wb_valid, 1'b1);
      chk("tbl_last_no_req", dmem_req_valid, 1'b0);
      tick();

      // SB 0x103, ready immediately: retire two cycles after issue
      run_store(32'h103, 2'd0, 32'h0000_00AB, 0, 32'h100, 4'b1000, 32'hAB00_0000, 32'hFF00_0000);
      // SH 0x202 into the upper half
      run_store(32'h202, 2'd1, 32'h1234_BEEF, 1, 32'h200, 4'b1100, 32'hBEEF_0000, 32'hFFFF_0000);
      // LB / LBU 0x102 with three wait cycles, LH sign extension at earliest response
      run_load(32'h102, 2'd0, 1'b0, 5'd7, 32'h0080_0000, 3, 32'h100, 4'b0100, 32'hFFFF_FF80);
      run_load(32'h102, 2'd0, 1'b1, 5'd8, 32'h0080_0000, 3, 32'h100, 4'b0100, 32'h0000_0080);
      run_load(32'h102, 2'd1, 1'b0, 5'd6, 32'h8001_0000, 0, 32'h100, 4'b1100, 32'hFFFF_8001);
      // SW with req_ready low 4 cycles, then LW right after: order kept
      run_store(32'h200, 2'd2, 32'hCAFE_BABE, 4, 32'h200, 4'b1111, 32'hCAFE_BABE, 32'hFFFF_FFFF);
      run_load(32'h204, 2'd2, 1'b0, 5'd10, 32'h1357_9BDF, 1, 32'h204, 4'b1111, 32'h1357_9BDF);

      // Reset while waiting in RSP; a late response must not retire anything
      dmem_req_ready = 1'b1;
      drive(32'h300, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1);
      tick();
      idle_ex();
      tick();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      chk("rsp_ex_ready_low", ex_ready, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_wb_valid", wb_valid, 1'b0);
      chk("midrst_req_valid", dmem_req_valid, 1'b0);
      chk("midrst_idle", ex_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      dmem_rsp_valid = 1'b1;
      dmem_rdata = 32'hAAAA_AAAA;
      tick();
      dmem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_rsp_ignored", wb_valid, 1'b0);
      chk("late_rsp_no_req", dmem_req_valid, 1'b0);
      chk("late_rsp_ex_ready", ex_ready, 1'b1);
      tick();
      tick();

      chk("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
